ucpu_micro_inst_decoder: RTL and testbench
==========================================

# ucpu_micro_inst_decoder

Registered decoder for the micro-sequenced CPU core. Splits one 44-bit micro-instruction into register specifiers, immediate, branch target and the control strobes for the ALU, register file, memory port and micro-PC sequencer. Sits between the micro-ROM output and the datapath. All outputs are registered, so results appear one clock after the instruction is presented.

## Interface
Parameters: none. Widths come from the shared defines.
- `MINST_WIDTH`: 44. Micro-instruction width.
- `REG_SPEC_WIDTH`: 5. Register specifier width.
- `IMM_WIDTH`: 8. Immediate width.
- `BRANCH_ADDR_WIDTH`: 8. Micro-PC width.
- `ALU_OPS`: 8. Number of ALU operations, so alu_op is 3 bits.

Ports. One clock; reset is asynchronous and active-low.
- `sys_clk`  in  1  Clock. All state updates on the rising edge.
- `sys_rst_n`  in  1  Asynchronous reset, active low.
- `minstr_in`  in  44  Micro-instruction.
- `reg_src_md`  out  5  Source register.
- `reg_dst_md`  out  5  Destination register.
- `imm_md`  out  8  Immediate.
- `branch_target`  out  8  Branch target micro-PC.
- `alu_en_md`  out  1  ALU enable.
- `alu_op_md`  out  3  ALU operation.
- `is_imm_active_md`  out  1  Selects the immediate as operand B.
- `reg_file_en_md`  out  1  Register file access enable.
- `reg_file_rw_md`  out  1  Register file direction: 1 = write, 0 = read.
- `mem_en_md`  out  1  Memory access enable.
- `mem_rw_md`  out  1  Memory direction: 1 = write, 0 = read.
- `is_branch_md`  out  1  Branch taken to branch_target.

## Operation
Field layout of `minstr_in`:
- [43:41] type
- [40:36] src
- [35:31] dst
- [30:20] immediate field; only [27:20] is used, [30:28] ignored
- [19:10] branch field; only [17:10] is used, [19:18] ignored
- [9:0] bus arguments

Bus arguments:
- [2:0] alu_op
- [5] wb, the write-back flag
- All other bits ignored.

The register, immediate and branch-target outputs are copied from their fields every cycle, whatever the type.

Control decode by type. Any signal not listed is 0.
- 0 ALU_RR: alu_en=1; alu_op=bus[2:0]; reg_file_en=1; reg_file_rw=wb.
- 1 ALU_RI: as ALU_RR, plus is_imm_active=1.
- 2 LOAD: mem_en=1; mem_rw=0; reg_file_en=1; reg_file_rw=1.
- 3 STORE: mem_en=1; mem_rw=1; reg_file_en=1; reg_file_rw=0.
- 4 LDI: is_imm_active=1; reg_file_en=1; reg_file_rw=1.
- 5 BRANCH: is_branch=1.
- 6 and 7 NOP: all control outputs 0.
- alu_op_md is 0 for every type other than 0 and 1.

## Timing
- Latency is 1 cycle: an instruction sampled at rising edge N drives the outputs from edge N until edge N+1.
- No handshake. A new instruction is accepted every cycle.
- Reset asserted: all outputs go to 0 immediately, asynchronously, and stay there while sys_rst_n=0. A reset-state decode is therefore equivalent to a NOP with all fields 0.
- Reset released: the first decode takes effect at the first rising edge with sys_rst_n=1.
- Reset asserted mid-stream: the instruction in flight is discarded. No partial output remains.
- X or undefined type values are not allowed to propagate. Types 6 and 7 must decode fully to NOP.

## Structure
- The shared defines header holds MINST_WIDTH, REG_SPEC_WIDTH, IMM_WIDTH, BRANCH_ADDR_WIDTH and ALU_OPS.
- The header also holds the field bit positions, the type encodings (MT_ALU_RR … MT_NOP) and the bus-argument bit indices.
- Natural split:
  - A combinational sub-module `micro_ctrl_lut` maps type and bus arguments to the control bits.
  - The top level does field slicing and owns the output register bank.

## Test plan
- Reset: assert sys_rst_n=0 mid-cycle -> all outputs 0 immediately, before any clock edge.
- ALU_RR: type 0, src 13, dst 5, bus 10'b0000100000, applied for one edge -> reg_src=13, reg_dst=5, alu_en=1, alu_op=0, reg_file_en=1, reg_file_rw=1; all other controls 0.
- ALU_RI: type 1, imm field 11'h7A5, bus 10'b0000000011, wb=0 -> imm_md=8'hA5, alu_op=3, is_imm=1, reg_file_rw=0.
- LOAD then STORE on consecutive cycles -> mem_rw goes 0 then 1 and reg_file_rw goes 1 then 0, each one cycle after its instruction is applied.
- BRANCH: type 5, branch field 10'h3C8 -> branch_target=8'hC8, is_branch=1, alu_en=0, mem_en=0.
- NOP: type 7 with all other bits 1 -> every control output 0; fields pass through (src=31, dst=31, imm=8'hFF).

Source files
------------

// File: rtl/ucpu_micro_inst_decoder_pkg.sv
// ucpu_micro_inst_decoder_pkg: shared widths, field positions, type encodings and control bundle
package ucpu_micro_inst_decoder_pkg;
    localparam int MINST_WIDTH       = 44;
    localparam int REG_SPEC_WIDTH    = 5;
    localparam int IMM_WIDTH         = 8;
    localparam int BRANCH_ADDR_WIDTH = 8;
    localparam int ALU_OPS           = 8;
    localparam int ALU_OP_WIDTH      = $clog2(ALU_OPS);

    localparam int TYPE_LSB   = 41;
    localparam int SRC_LSB    = 36;
    localparam int DST_LSB    = 31;
    localparam int IMM_LSB    = 20;
    localparam int BR_LSB     = 10;
    localparam int BUS_OP_LSB = 0;
    localparam int BUS_WB_BIT = 5;

    typedef enum logic [2:0] {
        MT_ALU_RR = 3'd0,
        MT_ALU_RI = 3'd1,
        MT_LOAD   = 3'd2,
        MT_STORE  = 3'd3,
        MT_LDI    = 3'd4,
        MT_BRANCH = 3'd5,
        MT_NOP6   = 3'd6,
        MT_NOP    = 3'd7
    } minst_type_e;

    typedef struct packed {
        logic                    alu_en;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    is_imm;
        logic                    rf_en;
        logic                    rf_rw;
        logic                    mem_en;
        logic                    mem_rw;
        logic                    is_branch;
    } ctrl_t;
endpackage

// File: rtl/ucpu_micro_inst_decoder_micro_ctrl_lut.sv
// micro_ctrl_lut: combinational map from micro-instruction type and bus arguments to control strobes
//   mtype  in  3  instruction type
//   alu_op in  3  ALU operation from the bus arguments
//   wb     in  1  write-back flag from the bus arguments
//   ctrl   out    decoded control bundle
module micro_ctrl_lut
    import ucpu_micro_inst_decoder_pkg::*;
(
    input  logic [2:0]              mtype,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic                    wb,
    output ctrl_t                   ctrl
);
    // Unknown or NOP types fall into the default and decode to all zeros.
    always_comb begin
        ctrl = '0;
        case (minst_type_e'(mtype))
            MT_ALU_RR: begin
                ctrl.alu_en = 1'b1;
                ctrl.alu_op = alu_op;
                ctrl.rf_en  = 1'b1;
                ctrl.rf_rw  = wb;
            end
            MT_ALU_RI: begin
                ctrl.alu_en = 1'b1;
                ctrl.alu_op = alu_op;
                ctrl.is_imm = 1'b1;
                ctrl.rf_en  = 1'b1;
                ctrl.rf_rw  = wb;
            end
            MT_LOAD: begin
                ctrl.mem_en = 1'b1;
                ctrl.rf_en  = 1'b1;
                ctrl.rf_rw  = 1'b1;
            end
            MT_STORE: begin
                ctrl.mem_en = 1'b1;
                ctrl.mem_rw = 1'b1;
                ctrl.rf_en  = 1'b1;
            end
            MT_LDI: begin
                ctrl.is_imm = 1'b1;
                ctrl.rf_en  = 1'b1;
                ctrl.rf_rw  = 1'b1;
            end
            MT_BRANCH: ctrl.is_branch = 1'b1;
            default:   ctrl = '0;
        endcase
    end
endmodule

// File: rtl/ucpu_micro_inst_decoder.sv
// ucpu_micro_inst_decoder: registered micro-instruction decoder, one cycle latency
//   sys_clk, sys_rst_n      clock and asynchronous active-low reset
//   minstr_in               44-bit micro-instruction
//   reg_src_md, reg_dst_md  register specifiers
//   imm_md, branch_target   immediate and branch micro-PC
//   *_en_md, *_rw_md, alu_op_md, is_imm_active_md, is_branch_md  control strobes
module ucpu_micro_inst_decoder
    import ucpu_micro_inst_decoder_pkg::*;
(
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [MINST_WIDTH-1:0]       minstr_in,
    output logic [REG_SPEC_WIDTH-1:0]    reg_src_md,
    output logic [REG_SPEC_WIDTH-1:0]    reg_dst_md,
    output logic [IMM_WIDTH-1:0]         imm_md,
    output logic [BRANCH_ADDR_WIDTH-1:0] branch_target,
    output logic                         alu_en_md,
    output logic [ALU_OP_WIDTH-1:0]      alu_op_md,
    output logic                         is_imm_active_md,
    output logic                         reg_file_en_md,
    output logic                         reg_file_rw_md,
    output logic                         mem_en_md,
    output logic                         mem_rw_md,
    output logic                         is_branch_md
);
    logic [REG_SPEC_WIDTH-1:0]    src_d, src_q, dst_d, dst_q;
    logic [IMM_WIDTH-1:0]         imm_d, imm_q;
    logic [BRANCH_ADDR_WIDTH-1:0] br_d, br_q;
    ctrl_t                        ctrl_d, ctrl_q;
    logic                         unused_bits;

    // Reserved bits of the immediate, branch and bus fields.
    assign unused_bits = ^{minstr_in[30:28], minstr_in[19:18], minstr_in[9:6], minstr_in[4:3]};

    micro_ctrl_lut u_lut (
        .mtype  (minstr_in[TYPE_LSB +: 3]),
        .alu_op (minstr_in[BUS_OP_LSB +: ALU_OP_WIDTH]),
        .wb     (minstr_in[BUS_WB_BIT]),
        .ctrl   (ctrl_d)
    );

    always_comb begin
        src_d = minstr_in[SRC_LSB +: REG_SPEC_WIDTH];
        dst_d = minstr_in[DST_LSB +: REG_SPEC_WIDTH];
        imm_d = minstr_in[IMM_LSB +: IMM_WIDTH];
        br_d  = minstr_in[BR_LSB +: BRANCH_ADDR_WIDTH];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            imm_q  <= '0;
            br_q   <= '0;
            ctrl_q <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            imm_q  <= imm_d;
            br_q   <= br_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign reg_src_md       = src_q;
    assign reg_dst_md       = dst_q;
    assign imm_md           = imm_q;
    assign branch_target    = br_q;
    assign alu_en_md        = ctrl_q.alu_en;
    assign alu_op_md        = ctrl_q.alu_op;
    assign is_imm_active_md = ctrl_q.is_imm;
    assign reg_file_en_md   = ctrl_q.rf_en;
    assign reg_file_rw_md   = ctrl_q.rf_rw;
    assign mem_en_md        = ctrl_q.mem_en;
    assign mem_rw_md        = ctrl_q.mem_rw;
    assign is_branch_md     = ctrl_q.is_branch;
endmodule

// File: tb/tb_ucpu_micro_inst_decoder.sv
// tb_ucpu_micro_inst_decoder: table-driven and scoreboarded check of the micro-instruction decoder
module tb_ucpu_micro_inst_decoder;
    // ctrl bits: {alu_en, alu_op[2:0], is_imm, rf_en, rf_rw, mem_en, mem_rw, is_branch}
    typedef struct packed {
        logic [4:0] src;
        logic [4:0] dst;
        logic [7:0] imm;
        logic [7:0] bt;
        logic [9:0] ctrl;
    } out_t;

    typedef struct {
        string       name;
        logic [43:0] instr;
        out_t        exp;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [43:0] minstr_in = '0;
    logic [4:0]  reg_src_md, reg_dst_md;
    logic [7:0]  imm_md, branch_target;
    logic        alu_en_md, is_imm_active_md, reg_file_en_md, reg_file_rw_md;
    logic        mem_en_md, mem_rw_md, is_branch_md;
    logic [2:0]  alu_op_md;

    int   n_checks = 0;
    int   n_fail = 0;
    out_t sb_q[$];
    vec_t tbl[10];

    ucpu_micro_inst_decoder dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .minstr_in        (minstr_in),
        .reg_src_md       (reg_src_md),
        .reg_dst_md       (reg_dst_md),
        .imm_md           (imm_md),
        .branch_target    (branch_target),
        .alu_en_md        (alu_en_md),
        .alu_op_md        (alu_op_md),
        .is_imm_active_md (is_imm_active_md),
        .reg_file_en_md   (reg_file_en_md),
        .reg_file_rw_md   (reg_file_rw_md),
        .mem_en_md        (mem_en_md),
        .mem_rw_md        (mem_rw_md),
        .is_branch_md     (is_branch_md)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [43:0] mk(input logic [2:0] t, input logic [4:0] s, input logic [4:0] d,
                                       input logic [10:0] im, input logic [9:0] br, input logic [9:0] bus);
        return {t, s, d, im, br, bus};
    endfunction

    function automatic out_t ev(input logic [4:0] s, input logic [4:0] d, input logic [7:0] im,
                                input logic [7:0] bt, input logic [9:0] c);
        out_t o;
        o.src = s; o.dst = d; o.imm = im; o.bt = bt; o.ctrl = c;
        return o;
    endfunction

    function automatic out_t model(input logic [43:0] i);
        out_t o;
        o.src = i[40:36];
        o.dst = i[35:31];
        o.imm = i[27:20];
        o.bt  = i[17:10];
        case (i[43:41])
            3'd0:    o.ctrl = {1'b1, i[2:0], 1'b0, 1'b1, i[5], 3'b000};
            3'd1:    o.ctrl = {1'b1, i[2:0], 1'b1, 1'b1, i[5], 3'b000};
            3'd2:    o.ctrl = 10'b0000011100;
            3'd3:    o.ctrl = 10'b0000010110;
            3'd4:    o.ctrl = 10'b0000111000;
            3'd5:    o.ctrl = 10'b0000000001;
            default: o.ctrl = 10'b0;
        endcase
        return o;
    endfunction

    function automatic out_t actual();
        return {reg_src_md, reg_dst_md, imm_md, branch_target, alu_en_md, alu_op_md, is_imm_active_md,
                reg_file_en_md, reg_file_rw_md, mem_en_md, mem_rw_md, is_branch_md};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [43:0] instr, input out_t exp);
        minstr_in = instr;
        sb_q.push_back(exp);
        @(posedge sys_clk);
        #1;
        check(name, sb_q.pop_front());
    endtask

    initial begin
        tbl[0] = '{"alu_rr",    mk(3'd0, 5'd13, 5'd5, 11'h0, 10'h0, 10'b0000100000), ev(5'd13, 5'd5, 8'h00, 8'h00, 10'b1000011000)};
        tbl[1] = '{"alu_ri",    mk(3'd1, 5'd0, 5'd0, 11'h7A5, 10'h0, 10'b0000000011), ev(5'd0, 5'd0, 8'hA5, 8'h00, 10'b1011110000)};
        tbl[2] = '{"load",      mk(3'd2, 5'd1, 5'd2, 11'h0, 10'h0, 10'h0), ev(5'd1, 5'd2, 8'h00, 8'h00, 10'b0000011100)};
        tbl[3] = '{"store",     mk(3'd3, 5'd3, 5'd4, 11'h0, 10'h0, 10'h0), ev(5'd3, 5'd4, 8'h00, 8'h00, 10'b0000010110)};
        tbl[4] = '{"branch",    mk(3'd5, 5'd0, 5'd0, 11'h0, 10'h3C8, 10'h0), ev(5'd0, 5'd0, 8'h00, 8'hC8, 10'b0000000001)};
        tbl[5] = '{"nop7",      mk(3'd7, 5'd31, 5'd31, 11'h7FF, 10'h3FF, 10'h3FF), ev(5'd31, 5'd31, 8'hFF, 8'hFF, 10'b0)};
        tbl[6] = '{"nop6",      mk(3'd6, 5'd31, 5'd31, 11'h7FF, 10'h3FF, 10'h3FF), ev(5'd31, 5'd31, 8'hFF, 8'hFF, 10'b0)};
        tbl[7] = '{"ldi",       mk(3'd4, 5'd3, 5'd4, 11'h012, 10'h0, 10'h3FF), ev(5'd3, 5'd4, 8'h12, 8'h00, 10'b0000111000)};
        tbl[8] = '{"load_bus1", mk(3'd2, 5'd9, 5'd17, 11'h0, 10'h0, 10'h3FF), ev(5'd9, 5'd17, 8'h00, 8'h00, 10'b0000011100)};
        tbl[9] = '{"alu_rr_ign", mk(3'd0, 5'd7, 5'd8, 11'h700, 10'h300, 10'b1111011101), ev(5'd7, 5'd8, 8'h00, 8'h00, 10'b1101010000)};

        #2;
        check("reset_initial", '0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        foreach (tbl[k]) step(tbl[k].name, tbl[k].instr, tbl[k].exp);

        for (int k = 0; k < 24; k++) begin
            logic [43:0] r;
            r = {$urandom_range(7, 0), $urandom(), $urandom_range(4095, 0)};
            step("random", r, model(r));
        end

        step("pre_reset", mk(3'd1, 5'd21, 5'd22, 11'h0BB, 10'h0CC, 10'b0000100111), ev(5'd21, 5'd22, 8'hBB, 8'hCC, 10'b1111111000));
        minstr_in = mk(3'd3, 5'd30, 5'd29, 11'h055, 10'h0AA, 10'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("reset_async", '0);
        @(posedge sys_clk);
        #1;
        check("reset_held", '0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", '0);
        step("after_reset_store", minstr_in, ev(5'd30, 5'd29, 8'h55, 8'hAA, 10'b0000010110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
